// File: rtl/fp_issue_pkg.sv
// ----------------------------------------------------------------------------
// fp_issue_pkg
// Shared constants and types for the FP issue controller:
//   - FP ALU control codes
//   - COP1 opcode / fmt / funct field encodings
//   - controller state enum and latency-class enum
//   - max4() helper used to size the latency counter
// ----------------------------------------------------------------------------
package fp_issue_pkg;

   // FP ALU control codes. Bit 3 makes the ALU update its condition flag.
   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0100;
   localparam logic [3:0] ALU_MUL = 4'b0001;
   localparam logic [3:0] ALU_DIV = 4'b0011;
   localparam logic [3:0] ALU_CEQ = 4'b1010;
   localparam logic [3:0] ALU_CLT = 4'b1000;
   localparam logic [3:0] ALU_CLE = 4'b1100;

   localparam logic [5:0] OP_COP1 = 6'b010001;

   localparam logic [4:0] FMT_S   = 5'b10000;
   localparam logic [4:0] FMT_D   = 5'b10001;
   localparam logic [4:0] FMT_BC1 = 5'b01000;

   localparam logic [5:0] FN_ADD = 6'b000000;
   localparam logic [5:0] FN_SUB = 6'b000001;
   localparam logic [5:0] FN_MUL = 6'b000010;
   localparam logic [5:0] FN_DIV = 6'b000011;
   localparam logic [5:0] FN_CEQ = 6'b110010;
   localparam logic [5:0] FN_CLT = 6'b111100;
   localparam logic [5:0] FN_CLE = 6'b111110;

   typedef enum logic [1:0] {IDLE, EXEC, WB} state_e;

   typedef enum logic [1:0] {LAT_ADDSUB, LAT_MUL, LAT_DIV, LAT_CMP} lat_sel_e;

   function automatic int max4(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

endpackage

// File: rtl/fp_issue_decode.sv
// ----------------------------------------------------------------------------
// fp_issue_decode
// Purely combinational COP1 decoder.
// Ports:
//   i_instr      in  32  MIPS instruction word
//   o_is_cop1    out 1   opcode is COP1
//   o_is_bc1     out 1   COP1 branch-on-condition (BC1T/BC1F)
//   o_legal      out 1   supported arithmetic / compare instruction
//   o_is_cmp     out 1   instruction is a compare
//   o_is_double  out 1   double-precision format
//   o_alu_ctrl   out 4   FP ALU control code for the operation
//   o_lat_sel    out 2   latency class of the operation
// ----------------------------------------------------------------------------
module fp_issue_decode
   import fp_issue_pkg::*;
(
   input  logic [31:0] i_instr,
   output logic        o_is_cop1,
   output logic        o_is_bc1,
   output logic        o_legal,
   output logic        o_is_cmp,
   output logic        o_is_double,
   output logic [3:0]  o_alu_ctrl,
   output lat_sel_e    o_lat_sel
);

   logic [4:0] w_fmt;
   logic [5:0] w_funct;
   logic       w_is_s;
   logic       w_is_d;
   logic       w_known;
   logic       w_addsub;
   logic       w_regs_even;

   assign w_fmt       = i_instr[25:21];
   assign w_funct     = i_instr[5:0];
   assign w_is_s      = (w_fmt == FMT_S);
   assign w_is_d      = (w_fmt == FMT_D);
   // Doubles occupy an even/odd register pair, so every operand must be even.
   assign w_regs_even = ~(i_instr[16] | i_instr[11] | i_instr[6]);

   always_comb begin
      o_alu_ctrl = ALU_ADD;
      o_lat_sel  = LAT_ADDSUB;
      o_is_cmp   = 1'b0;
      w_known    = 1'b1;
      w_addsub   = 1'b0;
      case (w_funct)
         FN_ADD: begin o_alu_ctrl = ALU_ADD; w_addsub = 1'b1; end
         FN_SUB: begin o_alu_ctrl = ALU_SUB; w_addsub = 1'b1; end
         FN_MUL: begin o_alu_ctrl = ALU_MUL; o_lat_sel = LAT_MUL; end
         FN_DIV: begin o_alu_ctrl = ALU_DIV; o_lat_sel = LAT_DIV; end
         FN_CEQ: begin o_alu_ctrl = ALU_CEQ; o_lat_sel = LAT_CMP; o_is_cmp = 1'b1; end
         FN_CLT: begin o_alu_ctrl = ALU_CLT; o_lat_sel = LAT_CMP; o_is_cmp = 1'b1; end
         FN_CLE: begin o_alu_ctrl = ALU_CLE; o_lat_sel = LAT_CMP; o_is_cmp = 1'b1; end
         default: w_known = 1'b0;
      endcase
   end

   assign o_is_cop1   = (i_instr[31:26] == OP_COP1);
   assign o_is_bc1    = o_is_cop1 & (w_fmt == FMT_BC1);
   assign o_is_double = w_is_d;
   // Double precision is only supported for add/sub.
   assign o_legal     = o_is_cop1 & w_known &
                        (w_is_s | (w_is_d & w_addsub & w_regs_even));

endmodule

// File: rtl/fp_issue_ctrl.sv
// ----------------------------------------------------------------------------
// fp_issue_ctrl
// Multi-cycle issue controller between decode and the FP ALU / register file.
// Accepts a COP1 instruction in IDLE, holds the ALU control for the
// operation's latency, then issues write enables (arith) or the condition
// update (compare). BC1 branches resolve combinationally in IDLE.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   i_instr_valid        instruction word is valid
//   i_instr[31:0]        MIPS instruction word
//   i_fp_cond            FP condition flag from the ALU
//   o_instr_ready        high exactly in IDLE
//   o_fp_stall           valid & ~ready
//   o_alu_ctrl[3:0]      FP ALU control code
//   o_is_double          double-precision select
//   o_fs/ft/fd_addr[4:0] latched register numbers
//   o_fp_wen_0/1         write enables for fd / fd+1
//   o_br_taken           BC1T/BC1F taken
//   o_illegal            one-cycle pulse after consuming an unsupported COP1 op
// ----------------------------------------------------------------------------
module fp_issue_ctrl
   import fp_issue_pkg::*;
#(
   parameter int ADDSUB_LAT = 1,
   parameter int MUL_LAT    = 3,
   parameter int DIV_LAT    = 8,
   parameter int CMP_LAT    = 1
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_instr_valid,
   input  logic [31:0] i_instr,
   input  logic        i_fp_cond,
   output logic        o_instr_ready,
   output logic        o_fp_stall,
   output logic [3:0]  o_alu_ctrl,
   output logic        o_is_double,
   output logic [4:0]  o_fs_addr,
   output logic [4:0]  o_ft_addr,
   output logic [4:0]  o_fd_addr,
   output logic        o_fp_wen_0,
   output logic        o_fp_wen_1,
   output logic        o_br_taken,
   output logic        o_illegal
);

   localparam int MAX_LAT = max4(ADDSUB_LAT, MUL_LAT, DIV_LAT, CMP_LAT);
   localparam int CW      = $clog2(MAX_LAT) + 1;

   state_e     r_state, w_state_next;
   logic [CW-1:0] r_cnt, w_cnt_next, w_lat;
   logic [3:0] r_op;
   logic       r_dbl, r_cmp, r_illegal;
   logic [4:0] r_fs, r_ft, r_fd;

   logic       w_dec_cop1, w_dec_bc1, w_dec_legal, w_dec_cmp, w_dec_dbl;
   logic [3:0] w_dec_op;
   lat_sel_e   w_dec_lat;
   logic       w_accept, w_start, w_illegal_next;

   fp_issue_decode u_decode (
      .i_instr     (i_instr),
      .o_is_cop1   (w_dec_cop1),
      .o_is_bc1    (w_dec_bc1),
      .o_legal     (w_dec_legal),
      .o_is_cmp    (w_dec_cmp),
      .o_is_double (w_dec_dbl),
      .o_alu_ctrl  (w_dec_op),
      .o_lat_sel   (w_dec_lat)
   );

   always_comb begin
      w_lat = CW'(ADDSUB_LAT);
      case (w_dec_lat)
         LAT_ADDSUB: w_lat = CW'(ADDSUB_LAT);
         LAT_MUL:    w_lat = CW'(MUL_LAT);
         LAT_DIV:    w_lat = CW'(DIV_LAT);
         LAT_CMP:    w_lat = CW'(CMP_LAT);
         default:    w_lat = CW'(ADDSUB_LAT);
      endcase
   end

   // Any COP1 word presented in IDLE is consumed; only legal ones start work.
   assign w_accept       = i_instr_valid & w_dec_cop1 & (r_state == IDLE);
   assign w_start        = w_accept & w_dec_legal;
   assign w_illegal_next = w_accept & ~w_dec_legal & ~w_dec_bc1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_op      <= ALU_ADD;
         r_dbl     <= 1'b0;
         r_cmp     <= 1'b0;
         r_fs      <= '0;
         r_ft      <= '0;
         r_fd      <= '0;
         r_illegal <= 1'b0;
      end else begin
         r_state   <= w_state_next;
         r_cnt     <= w_cnt_next;
         r_illegal <= w_illegal_next;
         if (w_start) begin
            r_op  <= w_dec_op;
            r_dbl <= w_dec_dbl;
            r_cmp <= w_dec_cmp;
            r_fs  <= i_instr[15:11];
            r_ft  <= i_instr[20:16];
            r_fd  <= i_instr[10:6];
         end
      end
   end

   always_comb begin
      w_state_next  = r_state;
      w_cnt_next    = r_cnt;
      o_instr_ready = 1'b0;
      o_alu_ctrl    = ALU_ADD;
      o_is_double   = 1'b0;
      o_fp_wen_0    = 1'b0;
      o_fp_wen_1    = 1'b0;
      o_br_taken    = 1'b0;
      case (r_state)
         IDLE: begin
            o_instr_ready = 1'b1;
            o_br_taken    = i_instr_valid & w_dec_bc1 &
                            (i_instr[16] ? i_fp_cond : ~i_fp_cond);
            if (w_start) begin
               w_cnt_next   = w_lat - CW'(1);
               w_state_next = (w_lat > CW'(1)) ? EXEC : WB;
            end
         end
         EXEC: begin
            // Compares must not touch the condition flag before WB.
            o_alu_ctrl  = r_cmp ? ALU_ADD : r_op;
            o_is_double = r_dbl;
            w_cnt_next  = r_cnt - CW'(1);
            // The decremented count reaching zero means this is the last EXEC cycle.
            if (r_cnt <= CW'(1)) w_state_next = WB;
         end
         WB: begin
            o_alu_ctrl   = r_op;
            o_is_double  = r_dbl;
            o_fp_wen_0   = ~r_cmp;
            o_fp_wen_1   = ~r_cmp & r_dbl;
            w_state_next = IDLE;
         end
         default: w_state_next = IDLE;
      endcase
   end

   assign o_fp_stall = i_instr_valid & ~o_instr_ready;
   assign o_fs_addr  = r_fs;
   assign o_ft_addr  = r_ft;
   assign o_fd_addr  = r_fd;
   assign o_illegal  = r_illegal;

endmodule

// File: doc/fp_issue_ctrl.md
# fp_issue_ctrl

Multi-cycle issue controller for the floating-point datapath: accepts COP1 instructions from the core, decodes them into the FP ALU's 4-bit control code and precision select, holds operands stable for a per-operation latency, then issues register-file write enables or the compare-condition update. It sits between the instruction decode stage and the FP ALU/FP register file. It stalls the core while an operation is in flight.

## Interface
Parameters:
- ADDSUB_LAT, 1, cycles an add/sub (single or double) is held before writeback (≥1)
- MUL_LAT, 3, cycles for mul.s (≥1)
- DIV_LAT, 8, cycles for div.s (≥1)
- CMP_LAT, 1, cycles for c.eq/c.lt/c.le (≥1)

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- instr_valid  in  1  instr carries a COP1 instruction
- instr  in  32  MIPS instruction word
- fp_cond  in  1  current FP condition flag from FP ALU
- instr_ready  out  1  controller can accept; high exactly in IDLE
- fp_stall  out  1  instr_valid & ~instr_ready
- alu_ctrl  out  4  FP ALU control code
- is_double  out  1  double-precision add/sub select
- fs_addr, ft_addr, fd_addr  out  5 each  latched source/destination register numbers
- fp_wen_0  out  1  write result word 0 to fd_addr
- fp_wen_1  out  1  write result word 1 to fd_addr+1 (double only)
- br_taken  out  1  BC1T/BC1F resolved taken (combinational, IDLE only)
- illegal  out  1  one-cycle pulse: unsupported COP1 instruction consumed

## Operation
- Opcode 6'b010001 only; other opcodes with instr_valid are ignored (no accept, no illegal).
- fmt instr[25:21]: 10000=S, 10001=D, 01000=BC1. funct instr[5:0]: add 000000, sub 000001, mul 000010, div 000011, c.eq 110010, c.lt 111100, c.le 111110.
- alu_ctrl codes: ADD 4'b0000, SUB 4'b0100, MUL 4'b0001, DIV 4'b0011, CEQ 4'b1010, CLT 4'b1000, CLE 4'b1100.
- The FP ALU updates its condition flag every cycle alu_ctrl[3]=1; therefore alu_ctrl[3] is driven 1 only in the WB cycle of a compare. Otherwise alu_ctrl = ADD when idle and during compare EXEC.
- Illegal: fmt D with mul/div/compare; D with odd fs/ft/fd; unknown funct; unknown fmt. Consumed in IDLE (ready high), illegal pulses the following cycle, state stays IDLE, no write.
- BC1 (fmt 01000): consumed in IDLE in one cycle; br_taken = instr_valid & (instr[16] ? fp_cond : ~fp_cond). No state change.
- FSM: IDLE, EXEC, WB.
  - IDLE + legal arith/compare: latch op, fmt, fs=instr[15:11], ft=instr[20:16], fd=instr[10:6]; cnt ← LAT−1; go EXEC if LAT>1 else WB.
  - EXEC: alu_ctrl/is_double held at latched op; cnt decrements; at cnt==0 go WB.
  - WB (1 cycle): arith asserts fp_wen_0, plus fp_wen_1 if double; compare drives its code with no write enables; go IDLE.
- Address outputs hold last latched values in IDLE; is_double=0 in IDLE.

## Timing
- Reset (async): state IDLE, cnt 0, alu_ctrl 4'b0000, is_double 0, addresses 0, wen/illegal 0. Reset mid-EXEC/WB aborts; no write issued.
- Accept edge = cycle 0; WB occurs in cycle LAT; next accept possible in cycle LAT+1. Total busy = LAT+1 cycles.
- Back-to-back: no bubble beyond the return to IDLE; instr_valid held with ready low is not consumed.
- cnt width = $clog2(max LAT)+1; no wrap: loaded only in IDLE.

## Structure
- Package fp_issue_pkg: alu_ctrl code constants, COP1 opcode/fmt/funct constants, state enum {IDLE, EXEC, WB}.
- One sub-module: fp_issue_decode (combinational: instr → op code, is_double, latency select, legal flag, is_bc1).

## Test plan
- add.d f2,f4,f6 with defaults → accept cycle 0, alu_ctrl 0000, is_double 1 in cycle 1; fp_wen_0=fp_wen_1=1, fd_addr=2 in cycle 1.
- div.s f1,f2,f3 → stall 8 cycles, alu_ctrl 0011 stable, single fp_wen_0 pulse in cycle 8, instr_ready back in cycle 9.
- c.lt.s then bc1t with fp_cond=1 → alu_ctrl 1000 only in WB cycle, no wen; bc1t gives br_taken=1; bc1f gives 0.
- mul.d f2,f4,f6 and add.d f3,f4,f6 → illegal pulse each, no wen, state stays IDLE.
- rst_n low during mul.s EXEC cycle 2 → outputs to reset values immediately, no wen ever, ready high after release.
